// File: rtl/alu_seq_core.sv
// alu_seq_core: sequential ALU driven by button-style strobes on a shared bus.
// Operands A/B and the opcode are loaded from i_sw on strobe rising edges.
// A load_op edge starts execution. Logic/arith ops take one edge. SRL/SRA
// shift one bit per edge.
// Ports:
//   i_clock                      rising-edge clock
//   i_reset                      synchronous, active-low reset
//   i_sw[NB_DATA-1:0]            operand / opcode bus (opcode in [NB_OP-1:0])
//   i_load_a/b/op, i_chain       level strobes, rising-edge triggered
//   o_result[NB_DATA-1:0]        registered result
//   o_carry/o_overflow/o_zero    registered flags
//   o_err                        last executed opcode was illegal
//   o_valid                      one-cycle pulse on result update
//   o_busy                       FSM not in IDLE
module alu_seq_core #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OP   = 6
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_sw,
    input  logic               i_load_a,
    input  logic               i_load_b,
    input  logic               i_load_op,
    input  logic               i_chain,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_carry,
    output logic               o_overflow,
    output logic               o_zero,
    output logic               o_err,
    output logic               o_valid,
    output logic               o_busy
);

    localparam int unsigned CNT_W = $clog2(NB_DATA);
    localparam int unsigned MSB   = NB_DATA - 1;

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] a_q, a_d, b_q, b_d, work_q, work_d, result_q, result_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               init_q, init_d;
    logic               carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
    logic               err_q, err_d, valid_q, valid_d, busy_q, busy_d;
    logic [3:0]         prev_q, strobes, acc;

    logic [NB_DATA:0]   sum, diff;
    logic [NB_DATA-1:0] alu_res;
    logic               alu_c, alu_v, alu_err;

    // Strobe vector ordered {chain, load_op, load_b, load_a}; accept 0->1 only.
    assign strobes = {i_chain, i_load_op, i_load_b, i_load_a};
    assign acc     = strobes & ~prev_q;

    // Single-cycle ALU for the EXEC path
    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        diff    = {1'b0, a_q} - {1'b0, b_q};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = sum[MSB:0];
                alu_c   = sum[NB_DATA];
                alu_v   = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                alu_res = diff[MSB:0];
                alu_c   = diff[NB_DATA];
                alu_v   = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_NOR:  alu_res = ~(a_q | b_q);
            default: alu_err = 1'b1;
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        init_d   = init_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Priority encode; lower-priority edges this cycle are dropped
                if (acc[0]) begin
                    a_d = i_sw;
                end else if (acc[1]) begin
                    b_d = i_sw;
                end else if (acc[2]) begin
                    op_d = i_sw[NB_OP-1:0];
                    if (i_sw[NB_OP-1:0] == OP_SRL || i_sw[NB_OP-1:0] == OP_SRA) begin
                        state_d = SHIFT;
                        init_d  = 1'b1;
                    end else begin
                        state_d = EXEC;
                    end
                end else if (acc[3]) begin
                    a_d = result_q;
                end
            end
            EXEC: begin
                result_d = alu_res;
                carry_d  = alu_c;
                ovf_d    = alu_v;
                err_d    = alu_err;
                zero_d   = (alu_res == '0);
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
            SHIFT: begin
                // First SHIFT cycle only loads work/count
                if (init_q) begin
                    work_d = a_q;
                    cnt_d  = b_q[CNT_W-1:0];
                    init_d = 1'b0;
                end else if (cnt_q == '0) begin
                    result_d = work_q;
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                    zero_d   = (work_q == '0);
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    work_d = {(op_q == OP_SRA) & work_q[MSB], work_q[MSB:1]};
                    cnt_d  = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            init_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b1;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            prev_q   <= '1;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            init_q   <= init_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            prev_q   <= strobes;
        end
    end

    assign o_result   = result_q;
    assign o_carry    = carry_q;
    assign o_overflow = ovf_q;
    assign o_zero     = zero_q;
    assign o_err      = err_q;
    assign o_valid    = valid_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed-vector bench for alu_seq_core at NB_DATA=8, NB_OP=6.
module tb_alu_seq_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw = '0;
    logic       ld_a = 1'b0, ld_b = 1'b0, ld_op = 1'b0, chain = 1'b0;
    logic [7:0] result;
    logic       carry, ovf, zero, err, valid, busy;

    int vectors = 0;
    int miscompares = 0;

    alu_seq_core #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clock(clk), .i_reset(rst_n), .i_sw(sw),
        .i_load_a(ld_a), .i_load_b(ld_b), .i_load_op(ld_op), .i_chain(chain),
        .o_result(result), .o_carry(carry), .o_overflow(ovf), .o_zero(zero),
        .o_err(err), .o_valid(valid), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic [7:0] v);
        sw = v; ld_a = 1'b1; step(); ld_a = 1'b0;
    endtask

    task automatic pulse_b(input logic [7:0] v);
        sw = v; ld_b = 1'b1; step(); ld_b = 1'b0;
    endtask

    task automatic pulse_chain();
        chain = 1'b1; step(); chain = 1'b0;
    endtask

    // Returns just after the acceptance edge
    task automatic pulse_op(input logic [5:0] op);
        sw = {2'b00, op}; ld_op = 1'b1; step(); ld_op = 1'b0;
    endtask

    // Issue a shift op and count edges until o_valid; optionally strobe load_a while busy
    task automatic shift_run(input logic [5:0] op, input bit poke, output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        pulse_op(op);
        for (int k = 1; k <= 20; k++) begin
            if (!busy) busy_ok = 1'b0;
            if (poke && k == 2) begin
                sw = 8'h55; ld_a = 1'b1;
            end else begin
                ld_a = 1'b0;
            end
            step();
            if (valid) begin
                lat = k;
                break;
            end
        end
        ld_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        vectors++;
        if ({result, carry, ovf, zero, err, valid, busy} !== {8'h00, 6'b001000}) begin
            miscompares++;
            $display("FAIL reset_state: got %h/%b%b%b%b%b%b want 00/001000",
                     result, carry, ovf, zero, err, valid, busy);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        pulse_a(8'hFF);
        pulse_b(8'hFF);
        pulse_op(6'b100000);
        vectors++;
        if ({busy, valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL add_accept: busy,valid=%b%b want 10", busy, valid);
        end
        step();
        vectors++;
        if ({result, carry, ovf, zero, err, valid} !== {8'hFE, 5'b10001}) begin
            miscompares++;
            $display("FAIL add_result: got %h c%b v%b z%b e%b val%b want FE c1 v0 z0 e0 val1",
                     result, carry, ovf, zero, err, valid);
        end
        step();
        vectors++;
        if ({result, valid, busy} !== {8'hFE, 2'b00}) begin
            miscompares++;
            $display("FAIL add_pulse_end: got %h val%b busy%b want FE val0 busy0", result, valid, busy);
        end
    endtask

    task automatic test_chain();
        pulse_chain();
        pulse_b(8'h02);
        pulse_op(6'b100000);
        step();
        vectors++;
        if ({result, carry, ovf, zero, err, valid} !== {8'h00, 5'b10101}) begin
            miscompares++;
            $display("FAIL chain_add: got %h c%b v%b z%b e%b val%b want 00 c1 v0 z1 e0 val1",
                     result, carry, ovf, zero, err, valid);
        end
        step();
    endtask

    task automatic test_sub();
        pulse_a(8'h80);
        pulse_b(8'h01);
        pulse_op(6'b100010);
        step();
        vectors++;
        if ({result, carry, ovf, zero, err, valid} !== {8'h7F, 5'b01001}) begin
            miscompares++;
            $display("FAIL sub_overflow: got %h c%b v%b z%b e%b val%b want 7F c0 v1 z0 e0 val1",
                     result, carry, ovf, zero, err, valid);
        end
        step();
        pulse_a(8'h01);
        pulse_b(8'h02);
        pulse_op(6'b100010);
        step();
        vectors++;
        if ({result, carry, ovf, zero, err, valid} !== {8'hFF, 5'b10001}) begin
            miscompares++;
            $display("FAIL sub_borrow: got %h c%b v%b z%b e%b val%b want FF c1 v0 z0 e0 val1",
                     result, carry, ovf, zero, err, valid);
        end
        step();
    endtask

    task automatic test_shift();
        int lat;
        bit busy_ok;
        pulse_a(8'h80);
        pulse_b(8'h03);
        shift_run(6'b000011, 1'b1, lat, busy_ok);
        vectors++;
        if (lat != 5 || !busy_ok) begin
            miscompares++;
            $display("FAIL sra_latency: latency %0d busy_ok %0b want 5 1 (0 = timeout)", lat, busy_ok);
        end
        vectors++;
        if ({result, carry, ovf, zero, err} !== {8'hF0, 4'b0000}) begin
            miscompares++;
            $display("FAIL sra_result: got %h c%b v%b z%b e%b want F0 0000", result, carry, ovf, zero, err);
        end
        step();
        vectors++;
        if ({valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL sra_pulse_end: val%b busy%b want 00", valid, busy);
        end
        // A must still be 80 despite the load_a strobe while busy
        shift_run(6'b000010, 1'b0, lat, busy_ok);
        vectors++;
        if (lat != 5 || result !== 8'h10) begin
            miscompares++;
            $display("FAIL srl_result: got %h latency %0d want 10 latency 5", result, lat);
        end
        step();
        pulse_b(8'h08);
        shift_run(6'b000010, 1'b0, lat, busy_ok);
        vectors++;
        if (lat != 2 || result !== 8'h80 || zero !== 1'b0) begin
            miscompares++;
            $display("FAIL srl_count0: got %h z%b latency %0d want 80 z0 latency 2", result, zero, lat);
        end
        step();
    endtask

    task automatic test_illegal();
        pulse_op(6'h3F);
        step();
        vectors++;
        if ({result, carry, ovf, zero, err, valid} !== {8'h00, 5'b00111}) begin
            miscompares++;
            $display("FAIL illegal_op: got %h c%b v%b z%b e%b val%b want 00 c0 v0 z1 e1 val1",
                     result, carry, ovf, zero, err, valid);
        end
        step();
        vectors++;
        if ({result, err, valid} !== {8'h00, 2'b10}) begin
            miscompares++;
            $display("FAIL illegal_hold: got %h e%b val%b want 00 e1 val0", result, err, valid);
        end
        // A=80, B=08 remain from the shift test
        pulse_op(6'b100000);
        step();
        vectors++;
        if ({result, carry, ovf, zero, err, valid} !== {8'h88, 5'b00001}) begin
            miscompares++;
            $display("FAIL err_clear: got %h c%b v%b z%b e%b val%b want 88 c0 v0 z0 e0 val1",
                     result, carry, ovf, zero, err, valid);
        end
        step();
    endtask

    task automatic test_priority();
        // load_a and load_op together: only A is loaded, op edge is dropped
        sw = 8'h05; ld_a = 1'b1; ld_op = 1'b1;
        step();
        ld_a = 1'b0; ld_op = 1'b0;
        step();
        vectors++;
        if ({busy, valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL priority_drop: busy%b val%b want 00", busy, valid);
        end
        pulse_op(6'b100000);
        step();
        vectors++;
        if ({result, valid} !== {8'h0D, 1'b1}) begin
            miscompares++;
            $display("FAIL priority_a: got %h val%b want 0D val1", result, valid);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bit saw_valid;
        pulse_a(8'h80);
        pulse_b(8'h05);
        pulse_op(6'b000011);
        step();
        step();
        rst_n = 1'b0; ld_a = 1'b1; sw = 8'h77;
        step();
        vectors++;
        if ({result, carry, ovf, zero, err, valid, busy} !== {8'h00, 6'b001000}) begin
            miscompares++;
            $display("FAIL reset_abort: got %h/%b%b%b%b%b%b want 00/001000",
                     result, carry, ovf, zero, err, valid, busy);
        end
        saw_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 1) rst_n = 1'b1;
            step();
            if (valid || busy) saw_valid = 1'b1;
        end
        vectors++;
        if (saw_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_valid: activity after reset got %b want 0", saw_valid);
        end
        ld_a = 1'b0;
        step();
        pulse_b(8'h01);
        pulse_op(6'b100000);
        step();
        vectors++;
        if ({result, valid} !== {8'h01, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_held_load_a: got %h val%b want 01 val1 (A should be 00)", result, valid);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_chain();
        test_sub();
        test_shift();
        test_illegal();
        test_priority();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_seq_core.md
ALU_SEQ_CORE -- requirements
Module: alu_seq_core

Interface
- REQ-001 SHALL have parameter NB_DATA, default 8: operand/result width, legal range 4..32.
- REQ-002 SHALL have parameter NB_OP, default 6: opcode width.
- REQ-003 SHALL have port i_clock, input, 1: single clock; all state updates on its rising edge.
- REQ-004 SHALL have port i_reset, input, 1: reset is synchronous and active-low.
- REQ-005 SHALL have port i_sw, input, NB_DATA: shared data bus for operand and opcode loads; opcode is taken from i_sw[NB_OP-1:0].
- REQ-006 SHALL have ports i_load_a, i_load_b and i_load_op, input, 1 each: level strobes (button-style); each acts only on its rising edge.
- REQ-007 SHALL have port i_chain, input, 1: level strobe; rising edge copies o_result into operand A.
- REQ-008 SHALL have port o_result, output, NB_DATA: registered result.
- REQ-009 SHALL have ports o_carry, o_overflow and o_zero, output, 1 each: registered flags.
- REQ-010 SHALL have port o_err, output, 1: registered flag, high when the last executed opcode was illegal.
- REQ-011 SHALL have port o_valid, output, 1: one-cycle pulse when o_result and the flags update.
- REQ-012 SHALL have port o_busy, output, 1: high while the FSM is not in IDLE.

Function
- REQ-013 SHALL detect edges by registering each strobe once and accepting a strobe only when its current sample is 1 and its previous sample is 0.
- REQ-014 SHALL, in IDLE, act on one accepted strobe per edge, with priority i_load_a > i_load_b > i_load_op > i_chain; lower-priority edges accepted on the same cycle are consumed and dropped.
- REQ-015 SHALL drop all strobe edges accepted while o_busy=1, without latching them.
- REQ-016 SHALL have FSM states IDLE, EXEC and SHIFT.
- REQ-017 SHALL perform these IDLE actions on an accepted strobe edge at clock edge N:
  - i_load_a: A <= i_sw at edge N.
  - i_load_b: B <= i_sw at edge N.
  - i_chain: A <= o_result at edge N.
  - i_load_op: OP <= i_sw[NB_OP-1:0] at edge N; go to SHIFT if OP is SRA or SRL, otherwise go to EXEC.
- REQ-018 SHALL use the opcodes ADD=100000, SUB=100010, AND=100100, OR=100101, XOR=100110, NOR=100111, SRL=000010 and SRA=000011; every other value is illegal.
- REQ-019 SHALL, in EXEC at edge N+1, register the result and flags, pulse o_valid, and return to IDLE (latency: 1 edge after op acceptance).
- REQ-020 SHALL, on SHIFT entry, load the work register with A and the count with B mod NB_DATA (low clog2(NB_DATA) bits of B).
- REQ-021 SHALL, at each following edge in SHIFT:
  - if count=0: o_result <= work, pulse o_valid, return to IDLE;
  - else: shift work right by 1 (SRL fills with 0, SRA replicates the MSB) and decrement count.
- REQ-022 SHALL give shift latency = count+2 edges after op acceptance (count 0 gives 2).
- REQ-023 SHALL compute ADD as (A+B) mod 2^NB_DATA, with o_carry = carry-out and o_overflow = signed overflow.
- REQ-024 SHALL compute SUB as (A-B) mod 2^NB_DATA, with o_carry = borrow (A<B unsigned) and o_overflow = signed overflow.
- REQ-025 SHALL clear o_carry and o_overflow for all other opcodes.
- REQ-026 SHALL set o_zero = (o_result==0) on every result update.
- REQ-027 SHALL, for an illegal opcode, take the EXEC path: o_result=0, o_err=1, o_zero=1, carry/overflow=0, o_valid pulsed; o_err clears on the next legal result.
- REQ-028 SHALL hold o_result and the flags between o_valid pulses.
- REQ-029 SHALL leave A, B and OP unchanged by execution, so a repeated i_load_op re-executes the same operation.

Reset
- REQ-030 SHALL, when i_reset=0 at a clock edge, clear A, B, OP, work, count, o_result, o_carry, o_overflow, o_err and o_valid, set o_zero=1, and enter IDLE.
- REQ-031 SHALL set the strobe history registers to 1 during reset, so strobes held high through reset release produce no edge.
- REQ-032 SHALL abort any EXEC or SHIFT in progress on reset, with no o_valid pulse and no partial result.

Verification (NB_DATA=8)
- REQ-033 SHALL cover: load A=FF, B=FF, OP=ADD -> o_result=FE, carry=1, overflow=0, zero=0; o_valid high for exactly 1 cycle, 1 edge after op acceptance.
- REQ-034 SHALL cover: A=80, B=01, OP=SUB -> o_result=7F, overflow=1, carry=0; then A=01, B=02, SUB -> o_result=FF, carry=1.
- REQ-035 SHALL cover: A=80, B=03, OP=SRA -> o_result=F0 after 5 edges with o_busy high throughout; a load_a strobe while busy is ignored (A still 80). Then OP=SRL -> o_result=10; B=08 (count 0) -> o_result=80 after 2 edges.
- REQ-036 SHALL cover: OP=3F -> o_err=1, o_result=00, zero=1, o_valid pulsed; next ADD clears o_err.
- REQ-037 SHALL cover: after o_result=FE, pulse i_chain, load B=02, OP=ADD -> o_result=00, zero=1, carry=1.
- REQ-038 SHALL cover: i_reset=0 mid-SRA with count 5 -> all outputs at reset values, no o_valid; load_a held high across reset release -> A remains 00.
